// File: rtl/seq_arb_4in_burst_pkg.sv
// -----------------------------------------------------------------------------
// seq_arb_4in_burst_pkg
// Shared definitions for the 4-input burst arbiter:
//   state_t       arbiter state (IDLE = no owner, BURST = owner locked)
//   NREQS         requester count
//   DATA_W        per-requester data width
//   CNT_W         width of the beat counter and burst limit (holds 1..16)
//   burst_limit() maps the 4-bit max_burst input to a beat limit (0 -> 16)
//   next_prio()   one-hot priority pointing just past a given requester
// -----------------------------------------------------------------------------
package seq_arb_4in_burst_pkg;

   localparam int NREQS  = 4;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   function automatic logic [CNT_W-1:0] burst_limit(input logic [3:0] mb);
      return (mb == 4'd0) ? 5'd16 : {1'b0, mb};
   endfunction

   // Round-robin rotation: the requester after the finishing owner gets first look.
   function automatic logic [3:0] next_prio(input logic [1:0] id);
      logic [1:0] w_nxt;
      w_nxt = id + 2'd1;
      return 4'b0001 << w_nxt;
   endfunction

endpackage

// File: rtl/seq_arb_4in_burst_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick_4
// Purely combinational round-robin picker. Scans reqs upward starting at the
// position marked by the one-hot prio vector, wrapping 3 -> 0, and returns a
// one-hot grant of the first set request (all zero when no request is set).
// Ports:
//   reqs   [3:0] in   request vector
//   prio   [3:0] in   one-hot starting position
//   grant  [3:0] out  one-hot grant
// -----------------------------------------------------------------------------
module rr_pick_4 (
   input  logic [3:0] reqs,
   input  logic [3:0] prio,
   output logic [3:0] grant
);

   logic [1:0] w_start;
   logic [1:0] w_idx;
   logic       w_found;

   // A malformed prio (not one-hot) falls back to its lowest set bit.
   always_comb begin
      w_start = 2'd0;
      if (prio[0])      w_start = 2'd0;
      else if (prio[1]) w_start = 2'd1;
      else if (prio[2]) w_start = 2'd2;
      else if (prio[3]) w_start = 2'd3;
   end

   always_comb begin
      grant   = 4'b0000;
      w_found = 1'b0;
      w_idx   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         w_idx = w_start + 2'(k);
         if (!w_found && reqs[w_idx]) begin
            grant[w_idx] = 1'b1;
            w_found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_arb_4in_burst.sv
// -----------------------------------------------------------------------------
// seq_arb_4in_burst
// Four-requester round-robin arbiter onto one shared valid/ready channel.
// A granted requester owns the channel until its last beat (in_last) or until
// the burst limit latched at grant time is reached. Arbitration in IDLE is
// zero-latency: the winner is presented in the same cycle it is chosen.
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   max_burst  in   beats per grant, 0 means 16 (sampled at grant only)
//   in_val     in   per-requester valid
//   in_rdy     out  per-requester ready (only the selected one follows out_rdy)
//   in_data    in   requester i data at bits [8i+7:8i]
//   in_last    in   per-requester last-beat flag
//   out_val    out  shared-channel valid
//   out_rdy    in   shared-channel ready
//   out_data   out  shared-channel data
//   out_last   out  beat ends the grant (in_last or burst limit)
//   out_id     out  index of the current owner
// -----------------------------------------------------------------------------
module seq_arb_4in_burst
   import seq_arb_4in_burst_pkg::*;
#(
   parameter int NREQS  = seq_arb_4in_burst_pkg::NREQS,
   parameter int DATA_W = seq_arb_4in_burst_pkg::DATA_W
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [3:0]                max_burst,
   input  logic [NREQS-1:0]          in_val,
   output logic [NREQS-1:0]          in_rdy,
   input  logic [NREQS*DATA_W-1:0]   in_data,
   input  logic [NREQS-1:0]          in_last,
   output logic                      out_val,
   input  logic                      out_rdy,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_last,
   output logic [1:0]                out_id
);

   state_t           r_state;
   logic [3:0]       r_prio;
   logic [1:0]       r_owner;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_limit;

   logic [3:0]        w_grant;
   logic [1:0]        w_pick_id;
   logic [1:0]        w_sel;
   logic              w_active;
   logic              w_fire;
   logic              w_term;
   logic [CNT_W-1:0]  w_cnt_cur;
   logic [CNT_W-1:0]  w_lim_cur;
   logic [DATA_W-1:0] w_sel_data;

   rr_pick_4 u_pick (
      .reqs  (in_val),
      .prio  (r_prio),
      .grant (w_grant)
   );

   always_comb begin
      w_pick_id = 2'd0;
      case (w_grant)
         4'b0010: w_pick_id = 2'd1;
         4'b0100: w_pick_id = 2'd2;
         4'b1000: w_pick_id = 2'd3;
         default: w_pick_id = 2'd0;
      endcase
   end

   // In IDLE the picker's winner is presented directly; count and limit are
   // what they will become on the grant, so a single-beat burst from IDLE is
   // recognised as terminal in the same cycle.
   always_comb begin
      w_sel      = (r_state == BURST) ? r_owner : w_pick_id;
      w_active   = reset_n && ((r_state == BURST) || (|in_val));
      w_cnt_cur  = (r_state == BURST) ? r_count : '0;
      w_lim_cur  = (r_state == BURST) ? r_limit : burst_limit(max_burst);
      w_sel_data = in_data[int'(w_sel)*DATA_W +: DATA_W];

      out_val    = w_active && in_val[w_sel];
      out_data   = w_active ? w_sel_data : '0;
      out_id     = w_active ? w_sel : 2'd0;
      in_rdy     = '0;
      if (w_active) in_rdy[w_sel] = out_rdy;

      w_term     = in_last[w_sel] || ((w_cnt_cur + 5'd1) == w_lim_cur);
      out_last   = out_val && w_term;
      w_fire     = out_val && out_rdy;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_prio  <= 4'b0001;
         r_owner <= 2'd0;
         r_count <= '0;
         r_limit <= 5'd16;
      end else begin
         case (r_state)
            IDLE: begin
               if (|in_val) begin
                  r_owner <= w_sel;
                  r_limit <= w_lim_cur;
                  if (w_fire && w_term) begin
                     // Single-beat grant: stay idle, rotate priority.
                     r_prio  <= next_prio(w_sel);
                     r_count <= '0;
                  end else if (w_fire) begin
                     r_state <= BURST;
                     r_count <= 5'd1;
                  end else begin
                     // Lock the winner so its beat stays stable until taken.
                     r_state <= BURST;
                     r_count <= '0;
                  end
               end
            end
            BURST: begin
               if (w_fire) begin
                  if (w_term) begin
                     r_state <= IDLE;
                     r_prio  <= next_prio(r_owner);
                     r_count <= '0;
                  end else begin
                     r_count <= r_count + 5'd1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_arb_4in_burst.sv
module tb_seq_arb_4in_burst;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic        clk;
   logic        reset_n;
   logic [3:0]  max_burst;
   logic [3:0]  in_val;
   logic [3:0]  in_rdy;
   logic [31:0] in_data;
   logic [3:0]  in_last;
   logic        out_val;
   logic        out_rdy;
   logic [7:0]  out_data;
   logic        out_last;
   logic [1:0]  out_id;

   beat_t exp_q[$];
   int    n_cmp;
   int    n_err;

   seq_arb_4in_burst dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .max_burst (max_burst),
      .in_val    (in_val),
      .in_rdy    (in_rdy),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_val   (out_val),
      .out_rdy   (out_rdy),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_id    (out_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every accepted beat must match the head of the expected queue.
   always @(negedge clk) begin
      if (reset_n && out_val && out_rdy) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL beat_unexpected: got id=%0d data=%h last=%b, required no beat",
                     out_id, out_data, out_last);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            if ({out_id, out_data, out_last} !== e) begin
               n_err++;
               $display("FAIL beat: got id=%0d data=%h last=%b, required id=%0d data=%h last=%b",
                        out_id, out_data, out_last, e.id, e.data, e.last);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] id, input logic [7:0] d, input logic l);
      beat_t b;
      b.id   = id;
      b.data = d;
      b.last = l;
      exp_q.push_back(b);
   endtask

   // Lane i carries 0x10*i + c so every beat is distinguishable.
   task automatic set_data(input int c);
      logic [7:0] cc;
      cc = 8'(c);
      in_data = {8'h30 + cc, 8'h20 + cc, 8'h10 + cc, 8'h00 + cc};
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_out_val"},  32'(out_val),  32'h0);
      chk({tag, "_in_rdy"},   32'(in_rdy),   32'h0);
      chk({tag, "_out_id"},   32'(out_id),   32'h0);
      chk({tag, "_out_data"}, 32'(out_data), 32'h0);
      chk({tag, "_out_last"}, 32'(out_last), 32'h0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      in_val  = 4'b0000;
      in_last = 4'b0000;
      out_rdy = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      reset_n   = 1'b0;
      max_burst = 4'd0;
      in_val    = 4'b1111;
      in_last   = 4'b0000;
      out_rdy   = 1'b1;
      in_data   = 32'h0;
      #3;
      // Reset holds outputs idle even with requests pending.
      chk_idle_outputs("in_reset");
      tick();
      do_reset();
      #1;
      chk_idle_outputs("post_reset");

      // 16-beat bursts with max_burst=0, then rotate to requester 1.
      max_burst = 4'd0;
      out_rdy   = 1'b1;
      in_val    = 4'b1111;
      for (int c = 0; c <= 16; c++) begin
         set_data(c);
         if (c < 16) push(2'd0, 8'(c), (c == 15));
         else        push(2'd1, 8'h10 + 8'(c), 1'b0);
         #1;
         if (c == 0)  chk("t1_in_rdy_first", 32'(in_rdy), 32'h1);
         if (c == 15) chk("t1_last_beat16",  32'(out_last), 32'h1);
         if (c == 16) chk("t1_next_owner",   32'(out_id), 32'h1);
         tick();
      end
      in_val = 4'b0000;
      chk("t1_queue_drained", 32'(exp_q.size()), 32'h0);

      // Requester 2 alone, in_last on beat 2, then priority points at 3.
      do_reset();
      max_burst = 4'd3;
      out_rdy   = 1'b1;
      in_val    = 4'b0100;
      set_data(0);
      push(2'd2, 8'h20, 1'b0);
      #1; chk("t2_id_beat1", 32'(out_id), 32'h2);
      tick();
      set_data(1);
      in_last = 4'b0100;
      push(2'd2, 8'h21, 1'b1);
      #1; chk("t2_last_beat2", 32'(out_last), 32'h1);
      tick();
      set_data(2);
      in_val  = 4'b1111;
      in_last = 4'b1111;
      push(2'd3, 8'h32, 1'b1);
      #1; chk("t2_prio_to_3", 32'(out_id), 32'h3);
      tick();
      set_data(3);
      push(2'd0, 8'h03, 1'b1);
      #1; chk("t2_wrap_to_0", 32'(out_id), 32'h0);
      tick();
      in_val  = 4'b0000;
      in_last = 4'b0000;
      #1; chk_idle_outputs("t2_idle");
      chk("t2_queue_drained", 32'(exp_q.size()), 32'h0);

      // Requester 1 stalled; requester 0 arriving must not steal the grant.
      do_reset();
      max_burst = 4'd0;
      out_rdy   = 1'b0;
      in_val    = 4'b0010;
      in_data   = 32'h4433_A511;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("t3_stall_id",   32'(out_id),   32'h1);
         chk("t3_stall_data", 32'(out_data), 32'hA5);
         chk("t3_stall_rdy",  32'(in_rdy),   32'h0);
         tick();
      end
      in_val  = 4'b0011;
      in_data = 32'h4433_A577;
      #1;
      chk("t3_hold_id",   32'(out_id),   32'h1);
      chk("t3_hold_data", 32'(out_data), 32'hA5);
      chk("t3_hold_rdy",  32'(in_rdy),   32'h0);
      tick();
      out_rdy = 1'b1;
      in_last = 4'b0011;
      push(2'd1, 8'hA5, 1'b1);
      #1; chk("t3_accept_rdy", 32'(in_rdy), 32'h2);
      tick();
      push(2'd0, 8'h77, 1'b1);
      #1; chk("t3_next_rdy", 32'(in_rdy), 32'h1);
      tick();
      in_val  = 4'b0000;
      in_last = 4'b0000;
      chk("t3_queue_drained", 32'(exp_q.size()), 32'h0);

      // Requester 3 with gaps; max_burst change mid-burst is ignored.
      do_reset();
      max_burst = 4'd4;
      out_rdy   = 1'b1;
      for (int c = 0; c < 8; c++) begin
         set_data(c);
         if (c == 2) max_burst = 4'd1;
         if (c == 0) begin
            in_val = 4'b1000;
            push(2'd3, 8'h30, 1'b0);
         end else if (c == 7) begin
            in_val = 4'b0001;
            push(2'd0, 8'h07, 1'b1);
         end else if (c[0]) begin
            in_val = 4'b0111;
         end else begin
            in_val = 4'b1111;
            push(2'd3, 8'h30 + 8'(c), (c == 6));
         end
         #1;
         if (c == 1 || c == 5) begin
            chk("t4_gap_val", 32'(out_val), 32'h0);
            chk("t4_gap_id",  32'(out_id),  32'h3);
            chk("t4_gap_rdy", 32'(in_rdy),  32'h8);
         end
         tick();
      end
      in_val = 4'b0000;
      chk("t4_queue_drained", 32'(exp_q.size()), 32'h0);

      // Reset during beat 2 of a 4-beat burst from requester 2.
      do_reset();
      max_burst = 4'd4;
      out_rdy   = 1'b1;
      in_val    = 4'b0100;
      set_data(0);
      push(2'd2, 8'h20, 1'b0);
      tick();
      set_data(1);
      #1;
      chk("t5_beat2_presented", 32'(out_id), 32'h2);
      #1;
      reset_n = 1'b0;
      #1;
      chk_idle_outputs("t5_mid_reset");
      tick();
      reset_n = 1'b1;
      in_val  = 4'b0110;
      in_last = 4'b0010;
      set_data(2);
      push(2'd1, 8'h12, 1'b1);
      #1; chk("t5_restart_winner", 32'(out_id), 32'h1);
      tick();
      in_val  = 4'b0000;
      in_last = 4'b0000;
      chk("t5_queue_drained", 32'(exp_q.size()), 32'h0);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required end of test");
      $fatal(1, "watchdog expired");
   end

endmodule
